// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM states and stream-format constants for the loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, BYTE, WRITE, RUN} state_t;
  localparam int LEN_BYTES = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: counts accepted data bytes and assembles little-endian 32-bit words
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic        last,
  output logic [31:0] word
);
  logic [1:0] cnt;
  assign last = cnt == 2'(WORD_BYTES - 1);
  // shifting in from the top leaves the first byte in bits 7:0 after four bytes
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      word <= {data, word[31:8]};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program into instruction memory, then releases the CPU
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              err
);
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;
  state_t state, state_nx;
  logic [15:0] n, n_in;
  logic [7:0] len_lo;
  logic [ADDR_W:0] idx, idx_nx;
  logic go, ovf, last;
  assign n_in     = {in_data, len_lo};
  assign ovf      = {1'b0, n_in} > MAX_N;
  assign idx_nx   = idx + 1'b1;
  assign go       = start && (state == IDLE || state == RUN);
  assign in_ready = state inside {LEN_LO, LEN_HI, BYTE};
  assign im_we    = state == WRITE;
  assign im_addr  = idx[ADDR_W-1:0];
  assign cpu_rstn = state != RUN;
  byte_packer u_packer (
    .clk (clk),
    .rst (rstn),
    .clr (go),
    .en  (in_valid && state == BYTE),
    .data(in_data),
    .last(last),
    .word(im_wdata)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? LEN_LO : IDLE;
      LEN_LO:  state_nx = in_valid ? LEN_HI : LEN_LO;
      LEN_HI:  state_nx = !in_valid ? LEN_HI : n_in == 16'd0 ? RUN : ovf ? IDLE : BYTE;
      BYTE:    state_nx = (in_valid && last) ? WRITE : BYTE;
      WRITE:   state_nx = (16'(idx_nx) < n) ? BYTE : RUN;
      RUN:     state_nx = start ? LEN_LO : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      state  <= IDLE;
      n      <= '0;
      len_lo <= '0;
      idx    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= state_nx == RUN && state != RUN;
      if (go) begin
        idx <= '0;
        n   <= '0;
        err <= 1'b0;
      end
      if (state == LEN_LO && in_valid) len_lo <= in_data;
      if (state == LEN_HI && in_valid) begin
        n <= n_in;
        if (ovf) err <= 1'b1;
      end
      if (state == WRITE) idx <= idx_nx;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 0, rstn = 0, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, im_we, cpu_rstn, done, err;
  logic [6:0] im_addr;
  logic [31:0] im_wdata;
  int total = 0, bad = 0, cyc = 0, wcount = 0, done_cnt = 0, we_cyc = 0, acc_cyc = 0, last_addr = 0;
  logic [31:0] wmem [128];

  imem_loader #(.ADDR_W(7)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rstn(cpu_rstn), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (im_we) begin
      wmem[im_addr] = im_wdata;
      wcount = wcount + 1;
      we_cyc = cyc;
      last_addr = int'(im_addr);
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clr_sb();
    wcount = 0;
    done_cnt = 0;
    for (int i = 0; i < 128; i++) wmem[i] = 32'h0;
  endtask

  task automatic do_reset();
    rstn = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    int tries;
    ok = 0;
    tries = 0;
    in_valid = 1;
    in_data = b;
    while (!ok && tries < 20) begin
      @(negedge clk);
      ok = in_ready;
      acc_cyc = cyc;
      @(posedge clk); #1;
      tries++;
    end
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
    in_valid = 0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int errs;
    do_reset();
    @(negedge clk);
    chk("rst_we", {31'd0, im_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_addr", {25'd0, im_addr}, 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    chk("rst_cpu", {31'd0, cpu_rstn}, 32'd1);
    @(posedge clk); #1;

    clr_sb();
    pulse_start();
    send_len(16'd2);
    send_word(32'h00500513, 0);
    send_word(32'h00A00593, 0);
    idle(4);
    @(negedge clk);
    chk("basic_wcount", wcount, 2);
    chk("basic_w0", wmem[0], 32'h00500513);
    chk("basic_w1", wmem[1], 32'h00A00593);
    chk("basic_done", done_cnt, 1);
    chk("basic_cpu", {31'd0, cpu_rstn}, 32'd0);
    chk("run_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;

    clr_sb();
    pulse_start();
    @(negedge clk);
    chk("reload_cpu", {31'd0, cpu_rstn}, 32'd1);
    @(posedge clk); #1;
    send_len(16'd1);
    send_word(32'hDEADBEEF, 3);
    idle(2);
    @(negedge clk);
    chk("gap_wcount", wcount, 1);
    chk("gap_w0", wmem[0], 32'hDEADBEEF);
    chk("gap_latency", we_cyc, acc_cyc + 1);
    chk("gap_done", done_cnt, 1);
    chk("gap_cpu", {31'd0, cpu_rstn}, 32'd0);
    @(posedge clk); #1;

    clr_sb();
    pulse_start();
    send_len(16'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    pulse_start();
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    idle(3);
    @(negedge clk);
    chk("midstart_wcount", wcount, 1);
    chk("midstart_w0", wmem[0], 32'hDDCCBBAA);
    @(posedge clk); #1;

    clr_sb();
    pulse_start();
    send_len(16'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    idle(2);
    @(negedge clk);
    chk("midrst_wcount", wcount, 0);
    chk("midrst_done", done_cnt, 0);
    chk("midrst_cpu", {31'd0, cpu_rstn}, 32'd1);
    @(posedge clk); #1;
    pulse_start();
    send_len(16'd1);
    send_word(32'h11223344, 0);
    idle(3);
    @(negedge clk);
    chk("midrst_reload_w0", wmem[0], 32'h11223344);
    chk("midrst_reload_addr", last_addr, 0);
    chk("midrst_reload_done", done_cnt, 1);
    @(posedge clk); #1;

    clr_sb();
    pulse_start();
    send_len(16'd0);
    idle(3);
    @(negedge clk);
    chk("n0_wcount", wcount, 0);
    chk("n0_done", done_cnt, 1);
    chk("n0_cpu", {31'd0, cpu_rstn}, 32'd0);
    @(posedge clk); #1;

    clr_sb();
    pulse_start();
    send_len(16'd128);
    for (int i = 0; i < 128; i++) send_word(32'h10000000 + i, 0);
    idle(3);
    @(negedge clk);
    errs = 0;
    for (int i = 0; i < 128; i++) if (wmem[i] !== 32'h10000000 + i) errs++;
    chk("n128_wcount", wcount, 128);
    chk("n128_data_errs", errs, 0);
    chk("n128_last_addr", last_addr, 127);
    chk("n128_done", done_cnt, 1);
    @(posedge clk); #1;

    clr_sb();
    pulse_start();
    send_len(16'd129);
    in_valid = 1;
    in_data = 8'h55;
    idle(3);
    @(negedge clk);
    chk("n129_err", {31'd0, err}, 32'd1);
    chk("n129_cpu", {31'd0, cpu_rstn}, 32'd1);
    chk("n129_idle_ready", {31'd0, in_ready}, 32'd0);
    chk("n129_wcount", wcount, 0);
    chk("n129_done", done_cnt, 0);
    @(posedge clk); #1;
    in_valid = 0;
    pulse_start();
    @(negedge clk);
    chk("err_clear", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, 7, instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 Ports (clock and reset first) SHALL be:
- clk  in  1  single clock, rising-edge.
- rstn  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse requesting a program load.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream payload.
- in_ready  out  1  byte accepted when in_valid and in_ready are both 1 at a clk edge.
- im_we  out  1  instruction-memory write enable.
- im_addr  out  ADDR_W  instruction-memory word address.
- im_wdata  out  32  instruction-memory write data.
- cpu_rstn  out  1  CPU reset, active-high: 1 holds the CPU in reset, 0 lets it run.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  sticky length-overflow flag.

Function
REQ-003 Stream format SHALL be a 16-bit little-endian word count N (2 bytes), followed by N 32-bit words, each little-endian (first byte to bits 7:0).
REQ-004 FSM states SHALL be IDLE, LEN_LO, LEN_HI, BYTE, WRITE and RUN.
REQ-005 IDLE -> LEN_LO on start; start SHALL be ignored in LEN_LO, LEN_HI, BYTE and WRITE.
REQ-006 LEN_LO -> LEN_HI on an accepted byte; LEN_HI -> BYTE on an accepted byte, with these exceptions:
- N == 0: LEN_HI SHALL go to RUN.
- N > 2^ADDR_W: LEN_HI SHALL go to IDLE and set err.
REQ-007 in_ready SHALL be 1 exactly in LEN_LO, LEN_HI and BYTE; bytes presented in any other state SHALL NOT be consumed.
REQ-008 BYTE SHALL count accepted bytes 0..3 with a 2-bit counter; the 4th accepted byte SHALL go to WRITE.
REQ-009 WRITE SHALL last one cycle, with im_we=1, im_wdata = the assembled word and im_addr = the current word index.
REQ-010 Write latency: im_we SHALL assert in the cycle immediately after the 4th byte is accepted.
REQ-011 After WRITE, the word index SHALL increment; next state is BYTE if index+1 < N, else RUN.
REQ-012 Word index SHALL start at 0 on every load and SHALL never wrap, since N <= 2^ADDR_W.
REQ-013 done SHALL pulse for exactly the one cycle in which the FSM enters RUN.
REQ-014 cpu_rstn SHALL be 0 only in RUN and 1 in every other state.
REQ-015 start in RUN SHALL go to LEN_LO, reasserting cpu_rstn from the next cycle.
REQ-016 err SHALL clear on the next start or on reset.
REQ-017 im_we SHALL be 0 in every state except WRITE.

Reset
REQ-018 When rstn=1 at a clk edge, the FSM SHALL go to IDLE and the following outputs SHALL be set:
- 0: im_we, done, err, in_ready, im_addr, im_wdata.
- 1: cpu_rstn.
- Byte counter, word index and N cleared.
REQ-019 Reset mid-load SHALL abandon the partial word: no im_we and no done.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state enumeration;
- constants LEN_BYTES=2 and WORD_BYTES=4.
REQ-021 One sub-module, byte_packer, SHALL hold the 2-bit byte counter and the 32-bit shift/assemble register. The FSM and counters SHALL remain in imem_loader.

Verification
REQ-022 Basic load, ADDR_W=7:
- Stimulus: start, then bytes 02 00 13 05 50 00 93 05 A0 00.
- Response: writes addr0=0x00500513 and addr1=0x00A00593; one done pulse; then cpu_rstn=0.
REQ-023 Valid gaps: in_valid low 3 cycles between every byte of a 1-word load (word 0xDEADBEEF) -> single write, addr0=0xDEADBEEF, written 1 cycle after the 4th byte.
REQ-024 Boundary:
- N=0 (00 00) -> no im_we; done pulses; cpu_rstn=0.
- N=128 -> addresses 0..127 written.
- N=129 -> err=1; FSM in IDLE; cpu_rstn stays 1; no im_we.
REQ-025 Mid-operation events:
- rstn pulsed after the 2nd data byte -> no write; cpu_rstn=1; a fresh start reloads from addr 0.
- start pulsed mid-load -> ignored.
REQ-026 Reload: start while in RUN -> cpu_rstn=1 next cycle; new program written from addr 0; done pulses again.
